// File: rtl/transposer_pkg.sv
// Shared types, constants and helpers for the
// ping-pong bit-plane transposer.
package transposer_pkg;

    localparam int unsigned MAX_PREC_DEF = 8;
    localparam int unsigned PREC_W = $clog2(MAX_PREC_DEF + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_t;

    function automatic logic prec_invalid(
        input logic [31:0] p,
        input int unsigned maxp
    );
        return (p == 32'd0) || (p > maxp);
    endfunction

    function automatic logic [31:0] prec_sanitize(
        input logic [31:0] p,
        input int unsigned maxp
    );
        return prec_invalid(p, maxp) ? maxp : p;
    endfunction

endpackage

// File: rtl/data_transposer_pp_bank.sv
// One transposer bank: bit-plane storage, lane write
// port, plane read mux and the block's latched config.
module transposer_bank
    import transposer_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = 64,
    parameter int unsigned LANES         = 4,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MVU_ADDR_LEN  = 32,
    parameter int unsigned MAX_DATA_PREC = MAX_PREC_DEF,
    localparam int unsigned BEATS = NUM_WORDS / LANES,
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1,
    localparam int unsigned PW = $clog2(MAX_DATA_PREC + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [BW-1:0]           wr_beat_i,
    input  logic [LANES*XLEN-1:0]   wr_words_i,
    input  logic                    cfg_en_i,
    input  logic [PW-1:0]           cfg_prec_i,
    input  logic [MVU_ADDR_LEN-1:0] cfg_baddr_i,
    input  logic                    cfg_msb_i,
    input  logic [PW-1:0]           rd_k_i,
    output logic [NUM_WORDS-1:0]    rd_word_o,
    output logic [PW-1:0]           prec_o,
    output logic [MVU_ADDR_LEN-1:0] baddr_o
);

    localparam int unsigned WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned IW = (MAX_DATA_PREC > 1) ? $clog2(MAX_DATA_PREC) : 1;

    logic [NUM_WORDS-1:0]    planes_q [MAX_DATA_PREC];
    logic [PW-1:0]           prec_q;
    logic [MVU_ADDR_LEN-1:0] baddr_q;
    logic                    msb_q;
    logic [WW-1:0]           base;
    logic [PW-1:0]           idx;
    logic                    unused_words;

    // Only the low precision bits of each lane word are stored.
    assign unused_words = ^wr_words_i;
    assign base = WW'(wr_beat_i) * WW'(LANES);

    // Lane write: each plane bit is assigned, never merged.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < MAX_DATA_PREC; b++)
                planes_q[b] <= '0;
        end else if (wr_en_i) begin
            for (int l = 0; l < LANES; l++)
                for (int b = 0; b < MAX_DATA_PREC; b++)
                    planes_q[b][base + WW'(l)] <= wr_words_i[l*XLEN + b];
        end
    end

    // Block config is latched on the first beat of a block.
    always_ff @(posedge clk) begin
        if (rst) begin
            prec_q  <= '0;
            baddr_q <= '0;
            msb_q   <= 1'b0;
        end else if (cfg_en_i) begin
            prec_q  <= cfg_prec_i;
            baddr_q <= cfg_baddr_i;
            msb_q   <= cfg_msb_i;
        end
    end

    // Plane select honours LSB- or MSB-first order.
    always_comb begin
        idx = rd_k_i;
        if (msb_q)
            idx = prec_q - PW'(1) - rd_k_i;
        rd_word_o = planes_q[idx[IW-1:0]];
    end

    assign prec_o  = prec_q;
    assign baddr_o = baddr_q;

endmodule

// File: rtl/data_transposer_pp.sv
// Ping-pong activation transposer: fills one bank with
// lane words while the other drains as bit-planes.
module data_transposer_pp
    import transposer_pkg::*;
#(
    parameter int unsigned NUM_WORDS     = 64,
    parameter int unsigned LANES         = 4,
    parameter int unsigned XLEN          = 32,
    parameter int unsigned MVU_ADDR_LEN  = 32,
    parameter int unsigned MAX_DATA_PREC = MAX_PREC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             prec,
    input  logic [MVU_ADDR_LEN-1:0] baddr,
    input  logic                    msb_first,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*XLEN-1:0]   in_words,
    output logic                    busy,
    output logic                    cfg_err,
    output logic                    mvu_wr_en,
    output logic [MVU_ADDR_LEN-1:0] mvu_wr_addr,
    output logic [NUM_WORDS-1:0]    mvu_wr_word,
    output logic                    blk_done
);

    localparam int unsigned BEATS = NUM_WORDS / LANES;
    localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned PW = $clog2(MAX_DATA_PREC + 1);

    drain_state_t            state_q, state_d;
    logic [PW-1:0]           k_q, k_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic [1:0]              full_q, full_d;
    logic                    fp_q, fp_d;
    logic                    dp_q, dp_d;
    logic                    err_q, err_d;
    logic                    wen_q, wen_d;
    logic [MVU_ADDR_LEN-1:0] addr_q, addr_d;
    logic [NUM_WORDS-1:0]    word_q, word_d;
    logic                    done_q, done_d;

    logic                    accept;
    logic                    first_beat;
    logic                    last_beat;
    logic [1:0]              wr_sel;
    logic [1:0]              cfg_sel;
    logic [PW-1:0]           sane_prec;
    logic [NUM_WORDS-1:0]    bank_word [2];
    logic [PW-1:0]           bank_prec [2];
    logic [MVU_ADDR_LEN-1:0] bank_baddr [2];
    logic [NUM_WORDS-1:0]    drain_word;
    logic [PW-1:0]           drain_prec;
    logic [MVU_ADDR_LEN-1:0] drain_baddr;

    assign in_ready   = ~full_q[fp_q];
    assign accept     = in_valid & in_ready;
    assign first_beat = accept && (beat_q == '0);
    assign last_beat  = accept && (beat_q == BW'(BEATS - 1));
    assign wr_sel     = accept ? (fp_q ? 2'b10 : 2'b01) : 2'b00;
    assign cfg_sel    = first_beat ? wr_sel : 2'b00;
    assign sane_prec  = PW'(prec_sanitize(prec, MAX_DATA_PREC));

    for (genvar g = 0; g < 2; g++) begin : g_bank
        transposer_bank #(
            .NUM_WORDS    (NUM_WORDS),
            .LANES        (LANES),
            .XLEN         (XLEN),
            .MVU_ADDR_LEN (MVU_ADDR_LEN),
            .MAX_DATA_PREC(MAX_DATA_PREC)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .wr_en_i    (wr_sel[g]),
            .wr_beat_i  (beat_q),
            .wr_words_i (in_words),
            .cfg_en_i   (cfg_sel[g]),
            .cfg_prec_i (sane_prec),
            .cfg_baddr_i(baddr),
            .cfg_msb_i  (msb_first),
            .rd_k_i     (k_q),
            .rd_word_o  (bank_word[g]),
            .prec_o     (bank_prec[g]),
            .baddr_o    (bank_baddr[g])
        );
    end

    assign drain_word  = bank_word[dp_q];
    assign drain_prec  = bank_prec[dp_q];
    assign drain_baddr = bank_baddr[dp_q];

    // Fill bookkeeping, drain FSM and next output values.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        beat_d  = beat_q;
        full_d  = full_q;
        fp_d    = fp_q;
        dp_d    = dp_q;
        err_d   = 1'b0;
        wen_d   = 1'b0;
        addr_d  = addr_q;
        word_d  = word_q;
        done_d  = 1'b0;

        if (accept) begin
            beat_d = beat_q + 1'b1;
            if (first_beat)
                err_d = prec_invalid(prec, MAX_DATA_PREC);
            if (last_beat) begin
                beat_d       = '0;
                full_d[fp_q] = 1'b1;
                fp_d         = ~fp_q;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (full_d[dp_q]) begin
                    state_d = DRAIN;
                    k_d     = '0;
                end
            end
            DRAIN: begin
                wen_d  = 1'b1;
                addr_d = drain_baddr + MVU_ADDR_LEN'(k_q);
                word_d = drain_word;
                if (k_q == drain_prec - PW'(1)) begin
                    done_d       = 1'b1;
                    full_d[dp_q] = 1'b0;
                    dp_d         = ~dp_q;
                    k_d          = '0;
                    state_d      = full_d[~dp_q] ? DRAIN : IDLE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
        endcase
    end

    // State and registered outputs; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            beat_q  <= '0;
            full_q  <= '0;
            fp_q    <= 1'b0;
            dp_q    <= 1'b0;
            err_q   <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            word_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            beat_q  <= beat_d;
            full_q  <= full_d;
            fp_q    <= fp_d;
            dp_q    <= dp_d;
            err_q   <= err_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            done_q  <= done_d;
        end
    end

    assign busy = (|full_q) | (beat_q != '0) | (state_q == DRAIN);
    assign cfg_err     = err_q;
    assign mvu_wr_en   = wen_q;
    assign mvu_wr_addr = addr_q;
    assign mvu_wr_word = word_q;
    assign blk_done    = done_q;

endmodule

// File: tb/tb_data_transposer_pp.sv
// Bench for data_transposer_pp: table-driven blocks plus
// back-to-back and mid-block reset sequences.
module tb_data_transposer_pp;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] word;
        logic        done;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] prec;
        logic [31:0] ba;
        logic        msb;
        int          mul;
        int          add;
        int          gap;
        int          exp_wr;
        int          exp_err;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [31:0]  prec;
    logic [31:0]  baddr;
    logic         msb_first;

    logic         in_valid1, in_ready1, busy1, cfg_err1;
    logic [127:0] in_words1;
    logic         wr_en1, done1;
    logic [31:0]  wr_addr1;
    logic [63:0]  wr_word1;

    logic         in_valid2, in_ready2, busy2, cfg_err2;
    logic [511:0] in_words2;
    logic         wr_en2, done2;
    logic [31:0]  wr_addr2;
    logic [63:0]  wr_word2;

    data_transposer_pp u_dut (
        .clk(clk), .rst(rst), .prec(prec), .baddr(baddr),
        .msb_first(msb_first), .in_valid(in_valid1),
        .in_ready(in_ready1), .in_words(in_words1),
        .busy(busy1), .cfg_err(cfg_err1),
        .mvu_wr_en(wr_en1), .mvu_wr_addr(wr_addr1),
        .mvu_wr_word(wr_word1), .blk_done(done1)
    );

    // Wide-lane instance: 4 beats per block, so drains
    // outlast fills and both banks can be full at once.
    data_transposer_pp #(.LANES(16)) u_dut2 (
        .clk(clk), .rst(rst), .prec(prec), .baddr(baddr),
        .msb_first(msb_first), .in_valid(in_valid2),
        .in_ready(in_ready2), .in_words(in_words2),
        .busy(busy2), .cfg_err(cfg_err2),
        .mvu_wr_en(wr_en2), .mvu_wr_addr(wr_addr2),
        .mvu_wr_word(wr_word2), .blk_done(done2)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int err1 = 0;
    int stall2 = 0;
    int last_acc = 0;
    wr_t got1[$];
    wr_t got2[$];
    wr_t exp_q[$];
    wr_t t1, t2;
    vec_t vecs[6];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en1) begin
            t1.addr = wr_addr1; t1.word = wr_word1;
            t1.done = done1; t1.cyc = cyc;
            got1.push_back(t1);
        end
        if (wr_en2) begin
            t2.addr = wr_addr2; t2.word = wr_word2;
            t2.done = done2; t2.cyc = cyc;
            got2.push_back(t2);
        end
        if (cfg_err1) err1++;
        if (in_valid2 && !in_ready2) stall2++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] dat(input int mul, input int add,
                                       input int w);
        return 8'(w * mul + add);
    endfunction

    task automatic expect_block(input vec_t v);
        int p;
        wr_t t;
        logic [7:0] d;
        p = (v.prec == 0 || v.prec > 8) ? 8 : int'(v.prec);
        for (int k = 0; k < p; k++) begin
            int idx;
            idx = v.msb ? (p - 1 - k) : k;
            t.addr = v.ba + 32'(k);
            for (int w = 0; w < 64; w++) begin
                d = dat(v.mul, v.add, w);
                t.word[w] = d[idx];
            end
            t.done = (k == p - 1);
            t.cyc = 0;
            exp_q.push_back(t);
        end
    endtask

    task automatic send(input int which, input vec_t v, input int nbeats);
        int k;
        int guard;
        int lanes;
        logic [511:0] bus;
        logic vld;
        logic rdy;
        k = 0;
        guard = 0;
        lanes = (which != 0) ? 16 : 4;
        prec = v.prec;
        baddr = v.ba;
        msb_first = v.msb;
        while (k < nbeats && guard < 2000) begin
            vld = ($urandom_range(99) >= v.gap);
            bus = '0;
            for (int l = 0; l < lanes; l++) begin
                int w;
                w = k * lanes + l;
                bus[l*32 +: 32] = {16'hBEEF, 8'(w) ^ 8'h5A, dat(v.mul, v.add, w)};
            end
            if (which == 0) begin
                in_valid1 = vld; in_words1 = bus[127:0]; rdy = in_ready1;
            end else begin
                in_valid2 = vld; in_words2 = bus; rdy = in_ready2;
            end
            if (vld && rdy) begin
                k++;
                if (k == nbeats) last_acc = cyc + 1;
            end
            guard++;
            tick();
        end
        if (k < nbeats) begin
            total++;
            bad++;
            $display("FAIL send_timeout act=%0d exp=%0d", k, nbeats);
        end
    endtask

    task automatic idle();
        in_valid1 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    function automatic int gsize(input int which);
        return (which != 0) ? got2.size() : got1.size();
    endfunction

    task automatic compare(input string tag, input int which);
        wr_t g[$];
        for (int i = 0; i < 400; i++) begin
            if (gsize(which) >= exp_q.size()) break;
            tick();
        end
        repeat (4) tick();
        g = (which != 0) ? got2 : got1;
        chk({tag, "_count"}, 64'(g.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < g.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(g[i].addr), 64'(exp_q[i].addr));
            chk($sformatf("%s_word%0d", tag, i), g[i].word, exp_q[i].word);
            chk($sformatf("%s_done%0d", tag, i), 64'(g[i].done), 64'(exp_q[i].done));
        end
    endtask

    initial begin
        vec_t v;
        rst = 1'b1;
        prec = '0; baddr = '0; msb_first = 1'b0;
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        in_words1 = '0; in_words2 = '0;

        //        prec  base           msb mul add gap wr err
        vecs[0] = '{32'd8, 32'h100, 1'b0, 1, 0, 0, 8, 0};
        vecs[1] = '{32'd4, 32'h100, 1'b1, 1, 0, 0, 4, 0};
        vecs[2] = '{32'd0, 32'h200, 1'b0, 3, 5, 0, 8, 1};
        vecs[3] = '{32'd9, 32'h300, 1'b1, 7, 1, 0, 8, 1};
        vecs[4] = '{32'd5, 32'h400, 1'b0, 13, 77, 30, 5, 0};
        vecs[5] = '{32'd3, 32'hFFFF_FFFE, 1'b0, 41, 200, 30, 3, 0};

        repeat (3) tick();
        rst = 1'b0;
        tick();

        chk("rst_wr_en", 64'(wr_en1), 64'd0);
        chk("rst_addr", 64'(wr_addr1), 64'd0);
        chk("rst_word", wr_word1, 64'd0);
        chk("rst_done", 64'(done1), 64'd0);
        chk("rst_cfg_err", 64'(cfg_err1), 64'd0);
        chk("rst_busy", 64'(busy1), 64'd0);
        chk("rst_in_ready", 64'(in_ready1), 64'd1);
        chk("rst_in_ready2", 64'(in_ready2), 64'd1);

        for (int vi = 0; vi < 6; vi++) begin
            got1.delete();
            exp_q.delete();
            err1 = 0;
            expect_block(vecs[vi]);
            send(0, vecs[vi], 16);
            idle();
            compare($sformatf("v%0d", vi), 0);
            chk($sformatf("v%0d_nwr", vi), 64'(got1.size()), 64'(vecs[vi].exp_wr));
            chk($sformatf("v%0d_cfg_err", vi), 64'(err1), 64'(vecs[vi].exp_err));
            chk($sformatf("v%0d_busy_end", vi), 64'(busy1), 64'd0);
            if (vi == 0) begin
                chk("lat_first_wr", 64'(got1[0].cyc - last_acc), 64'd1);
                chk("lsb_plane0", got1[0].word, 64'hAAAA_AAAA_AAAA_AAAA);
                chk("lsb_plane5", got1[5].word, 64'hFFFF_FFFF_0000_0000);
                chk("lsb_plane7", got1[7].word, 64'h0);
                chk("lsb_last_addr", 64'(got1[7].addr), 64'h107);
                chk("lsb_last_done", 64'(got1[7].done), 64'd1);
                chk("lsb_mid_done", 64'(got1[6].done), 64'd0);
            end
            if (vi == 1) begin
                chk("msb_first_plane3", got1[0].word, 64'hFF00_FF00_FF00_FF00);
                chk("msb_last_plane0", got1[3].word, 64'hAAAA_AAAA_AAAA_AAAA);
                chk("msb_last_addr", 64'(got1[3].addr), 64'h103);
            end
        end

        // Three blocks back-to-back on the wide-lane instance.
        got2.delete();
        exp_q.delete();
        stall2 = 0;
        for (int b = 0; b < 3; b++) begin
            v = '{32'd8, 32'h1000 * (b + 1), 1'(b == 1), 2 * b + 1, 9 * b, 0, 8, 0};
            expect_block(v);
            send(1, v, 4);
        end
        idle();
        compare("b2b", 1);
        chk("b2b_stall_seen", 64'(stall2 > 0), 64'd1);
        chk("b2b_no_gap", 64'(got2[23].cyc - got2[0].cyc), 64'd23);

        // Reset in the middle of a drain discards the rest.
        got1.delete();
        v = '{32'd8, 32'h600, 1'b0, 11, 2, 0, 8, 0};
        send(0, v, 16);
        idle();
        for (int i = 0; i < 100 && got1.size() < 3; i++) tick();
        rst = 1'b1;
        tick();
        chk("rstd_wr_en", 64'(wr_en1), 64'd0);
        chk("rstd_addr", 64'(wr_addr1), 64'd0);
        chk("rstd_word", wr_word1, 64'd0);
        chk("rstd_busy", 64'(busy1), 64'd0);
        rst = 1'b0;
        repeat (12) tick();
        chk("rstd_nwr", 64'(got1.size()), 64'd3);

        // Reset after beat 7 of a block, then a fresh block.
        v = '{32'd2, 32'h700, 1'b1, 29, 6, 0, 2, 0};
        send(0, v, 8);
        idle();
        rst = 1'b1;
        tick();
        chk("rstp_busy", 64'(busy1), 64'd0);
        chk("rstp_in_ready", 64'(in_ready1), 64'd1);
        chk("rstp_wr_en", 64'(wr_en1), 64'd0);
        rst = 1'b0;
        tick();
        got1.delete();
        exp_q.delete();
        v = '{32'd6, 32'h800, 1'b0, 19, 4, 20, 6, 0};
        expect_block(v);
        send(0, v, 16);
        idle();
        compare("rstp_new", 0);
        chk("rstp_nwr", 64'(got1.size()), 64'd6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
